lcd_line_ctrl: RTL

Sequential HD44780-style LCD line controller for the operand/operation display path. It performs the power-up init sequence, then on request rewrites one full display line of NUM_CHARS characters. Characters are fetched by index from an external combinational character source, which is the operand/mnemonic datapath. It generates E/RS/RW timing, a blinking cursor blank, and a request/busy/done handshake.

---
 rtl/lcd_line_ctrl_if.sv | 29 ++
 rtl/lcd_line_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_line_ctrl_if.sv
// Signal bundle between the LCD line controller, its requester/character source and the LCD pins.
interface lcd_line_ctrl_if #(
    parameter int NUM_CHARS = 16
);
    localparam int IW = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

    logic          refresh;
    logic          cursor_en;
    logic [IW-1:0] cursor_pos;
    logic [IW-1:0] char_idx;
    logic [7:0]    char_data;
    logic          init_done;
    logic          busy;
    logic          frame_done;
    logic [7:0]    lcd_db;
    logic          lcd_rs;
    logic          lcd_rw;
    logic          lcd_e;

    modport slave (
        input  refresh, cursor_en, cursor_pos, char_data,
        output char_idx, init_done, busy, frame_done, lcd_db, lcd_rs, lcd_rw, lcd_e
    );

    modport master (
        output refresh, cursor_en, cursor_pos, char_data,
        input  char_idx, init_done, busy, frame_done, lcd_db, lcd_rs, lcd_rw, lcd_e
    );
endinterface

// File: rtl/lcd_line_ctrl.sv
// HD44780-style line controller: power-up init, then on request rewrites one display line
// fetched character by character from a combinational source, with a blinking cursor blank.
module lcd_line_ctrl #(
    parameter int         NUM_CHARS      = 16,
    parameter logic [7:0] LINE_ADDR      = 8'h80,
    parameter int         POWERUP_CYC    = 750000,
    parameter int         E_SETUP_CYC    = 2,
    parameter int         E_HIGH_CYC     = 12,
    parameter int         CMD_WAIT_CYC   = 2000,
    parameter int         CLEAR_WAIT_CYC = 82000,
    parameter int         BLINK_CYC      = 12500000
) (
    input  logic           clk,
    input  logic           rst_n,
    lcd_line_ctrl_if.slave bus
);
    localparam int IW    = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam int PW    = (IW > 2) ? IW : 2;
    localparam int MAX_A = (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
    localparam int MAX_B = (CMD_WAIT_CYC > E_HIGH_CYC) ? CMD_WAIT_CYC : E_HIGH_CYC;
    localparam int MAX_C = (MAX_B > E_SETUP_CYC) ? MAX_B : E_SETUP_CYC;
    localparam int MAXC  = (MAX_A > MAX_C) ? MAX_A : MAX_C;
    localparam int CW    = $clog2(MAXC + 1);
    localparam int BW    = $clog2(BLINK_CYC + 1);

    localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_CYC - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(E_SETUP_CYC - 1);
    localparam logic [CW-1:0] HI_LAST  = CW'(E_HIGH_CYC - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT_CYC - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_WAIT_CYC - 1);
    localparam logic [BW-1:0] BL_LAST  = BW'(BLINK_CYC - 1);

    typedef enum logic [2:0] {S_PWRUP, S_INIT, S_IDLE, S_ADDR, S_DATA} state_t;
    typedef enum logic [1:0] {B_SETUP, B_PULSE, B_WAIT} bph_t;

    state_t        state_q, state_d;
    bph_t          bph_q, bph_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] seq_q, seq_d;
    logic [IW-1:0] char_idx_q, char_idx_d;
    logic [7:0]    db_q, db_d;
    logic          rs_q, rs_d;
    logic          e_q, e_d;
    logic          init_done_q, init_done_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          pending_q, pending_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;

    logic [CW-1:0] wait_last;
    logic          last_init, last_chr;
    logic [7:0]    data_byte;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    assign last_init = (seq_q == PW'(3));
    assign last_chr  = (seq_q == PW'(NUM_CHARS - 1));
    assign wait_last = (state_q == S_INIT && last_init) ? CLR_LAST : CMD_LAST;
    // char_idx never leaves 0..NUM_CHARS-1, so an out-of-range cursor_pos can never match
    assign data_byte = (bus.cursor_en && blink_q && bus.cursor_pos == char_idx_q) ? 8'h20
                                                                                  : bus.char_data;

    always_comb begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        blink_d     = blink_q;
        if (blink_cnt_q == BL_LAST) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        bph_d        = bph_q;
        cnt_d        = cnt_q + CW'(1);
        seq_d        = seq_q;
        char_idx_d   = char_idx_q;
        db_d         = db_q;
        rs_d         = rs_q;
        init_done_d  = init_done_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        pending_d    = pending_q;
        if (bus.refresh && state_q != S_IDLE) pending_d = 1'b1;

        case (state_q)
            S_PWRUP: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = S_INIT;
                    bph_d   = B_SETUP;
                    cnt_d   = '0;
                    seq_d   = '0;
                    db_d    = init_cmd(2'd0);
                    rs_d    = 1'b0;
                end
            end
            S_IDLE: begin
                cnt_d = '0;
                if (bus.refresh || pending_q) begin
                    pending_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_ADDR;
                    bph_d     = B_SETUP;
                    db_d      = LINE_ADDR;
                    rs_d      = 1'b0;
                end
            end
            default: begin
                case (bph_q)
                    B_SETUP: begin
                        if (cnt_q == SET_LAST) begin
                            bph_d = B_PULSE;
                            cnt_d = '0;
                        end
                    end
                    B_PULSE: begin
                        if (cnt_q == HI_LAST) begin
                            bph_d = B_WAIT;
                            cnt_d = '0;
                            // present the next index early so the datapath settles during WAIT
                            if (state_q == S_DATA && !last_chr) char_idx_d = char_idx_q + IW'(1);
                        end
                    end
                    default: begin
                        if (cnt_q == wait_last) begin
                            bph_d = B_SETUP;
                            cnt_d = '0;
                            case (state_q)
                                S_INIT: begin
                                    if (last_init) begin
                                        state_d     = S_IDLE;
                                        init_done_d = 1'b1;
                                        busy_d      = 1'b0;
                                    end else begin
                                        seq_d = seq_q + PW'(1);
                                        db_d  = init_cmd(seq_q[1:0] + 2'd1);
                                    end
                                end
                                S_ADDR: begin
                                    state_d = S_DATA;
                                    seq_d   = '0;
                                    db_d    = data_byte;
                                    rs_d    = 1'b1;
                                end
                                default: begin
                                    if (last_chr) begin
                                        state_d      = S_IDLE;
                                        frame_done_d = 1'b1;
                                        busy_d       = 1'b0;
                                        char_idx_d   = '0;
                                    end else begin
                                        seq_d = seq_q + PW'(1);
                                        db_d  = data_byte;
                                    end
                                end
                            endcase
                        end
                    end
                endcase
            end
        endcase

        e_d = (bph_d == B_PULSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_PWRUP;
            bph_q        <= B_SETUP;
            cnt_q        <= '0;
            seq_q        <= '0;
            char_idx_q   <= '0;
            db_q         <= '0;
            rs_q         <= 1'b0;
            e_q          <= 1'b0;
            init_done_q  <= 1'b0;
            busy_q       <= 1'b1;
            frame_done_q <= 1'b0;
            pending_q    <= 1'b0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            bph_q        <= bph_d;
            cnt_q        <= cnt_d;
            seq_q        <= seq_d;
            char_idx_q   <= char_idx_d;
            db_q         <= db_d;
            rs_q         <= rs_d;
            e_q          <= e_d;
            init_done_q  <= init_done_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            pending_q    <= pending_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
        end
    end

    assign bus.char_idx   = char_idx_q;
    assign bus.init_done  = init_done_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.lcd_db     = db_q;
    assign bus.lcd_rs     = rs_q;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_e      = e_q;
endmodule
